// File: rtl/count_ones_sm_param_if.sv
// Start/busy/done handshake bundle for the multi-bit population counter.
// master = controller side, slave = counter side.
interface count_ones_sm_param_if #(
    parameter int WORD_SIZE    = 8,
    parameter int COUNTER_SIZE = 4
);
    logic                    start;
    logic                    mode;
    logic [WORD_SIZE-1:0]    data;
    logic [COUNTER_SIZE-1:0] bit_count;
    logic                    busy;
    logic                    done;

    modport master (
        output start, mode, data,
        input  bit_count, busy, done
    );

    modport slave (
        input  start, mode, data,
        output bit_count, busy, done
    );
endinterface

// File: rtl/count_ones_sm_param.sv
// Parametrised ones/zeros counter, BITS_PER_CYCLE bits per clock.
// Optional macro COUNT_ONES_SM_EARLY_EXIT_EN: stop once the remaining word is zero.
module count_ones_sm_param #(
    parameter int WORD_SIZE      = 8,
    parameter int COUNTER_SIZE   = 4,
    parameter int BITS_PER_CYCLE = 2
) (
    input logic                 clk,
    input logic                 reset,
    count_ones_sm_param_if.slave bus
);
    localparam int N  = WORD_SIZE / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_SIZE-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]           chunk_q, chunk_d;
    logic [COUNTER_SIZE-1:0] bit_count_q, bit_count_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [COUNTER_SIZE-1:0] chunk_ones;
    logic [WORD_SIZE-1:0]    shifted;
    logic                    finish;

    // Next-state and datapath: load on start, accumulate one chunk per clock
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        chunk_d     = chunk_q;
        bit_count_d = bit_count_q;
        chunk_ones  = '0;
        shifted     = shreg_q >> BITS_PER_CYCLE;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            chunk_ones = chunk_ones + COUNTER_SIZE'(shreg_q[i]);
        end
`ifdef COUNT_ONES_SM_EARLY_EXIT_EN
        finish = (chunk_q == CW'(N - 1)) || (shifted == '0);
`else
        finish = (chunk_q == CW'(N - 1));
`endif
        case (state_q)
            S_IDLE, S_WAIT: begin
                if (bus.start) begin
                    shreg_d     = bus.mode ? ~bus.data : bus.data;
                    chunk_d     = '0;
                    bit_count_d = '0;
                    state_d     = S_COUNT;
                end
            end
            S_COUNT: begin
                bit_count_d = bit_count_q + chunk_ones;
                shreg_d     = shifted;
                chunk_d     = chunk_q + 1'b1;
                if (finish) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d     = S_IDLE;
                shreg_d     = '0;
                chunk_d     = '0;
                bit_count_d = '0;
            end
        endcase
        busy_d = (state_d == S_COUNT);
        done_d = (state_d == S_WAIT);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            chunk_q     <= '0;
            bit_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            chunk_q     <= chunk_d;
            bit_count_q <= bit_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.bit_count = bit_count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: doc/count_ones_sm_param.md
Name: count_ones_sm_param

Overview:
- Parametrised multi-bit population counter driven by a start/busy/done handshake.
- Next generation of the single-bit count-ones state machine: configurable word width, several bits examined per clock, and a runtime mode select that counts either ones or zeros.
- Used as a datapath utility block under a controller that issues start and waits for done.

Parameters:
- WORD_SIZE, 8: width of the data input; must be a multiple of BITS_PER_CYCLE.
- COUNTER_SIZE, 4: width of bit_count; must satisfy 2**COUNTER_SIZE > WORD_SIZE.
- BITS_PER_CYCLE, 2: bits examined per clock; 1, 2, 4 or 8.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in S_IDLE or S_WAIT.
- mode  input  1  0 = count ones, 1 = count zeros; sampled with start.
- data  input  WORD_SIZE  word to count; sampled with start.
- bit_count  output  COUNTER_SIZE  running count, final when done=1.
- busy  output  1  high while in S_COUNT.
- done  output  1  high while in S_WAIT.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset; it overrides all other inputs.
- Reset values:
  - state = S_IDLE
  - bit_count = 0, busy = 0, done = 0
  - shift register and chunk counter = 0
- Registers:
  - shreg: WORD_SIZE bits.
  - chunk: counts 0 to N-1, where N = WORD_SIZE/BITS_PER_CYCLE.
- S_IDLE:
  - start=1 at an edge loads shreg = data (mode=0) or ~data (mode=1), clears bit_count and chunk, and moves to S_COUNT.
  - start=0: stay in S_IDLE.
- S_COUNT (busy=1, done=0), at each edge:
  - bit_count += popcount(shreg[BITS_PER_CYCLE-1:0])
  - shreg >>= BITS_PER_CYCLE, zero-filled
  - chunk += 1
  - Move to S_WAIT when chunk == N-1, or on early exit (see Optional Feature); otherwise stay.
- S_WAIT (busy=0, done=1):
  - bit_count holds its final value.
  - start=1 at an edge performs the same load as in S_IDLE and goes straight to S_COUNT (back-to-back operation, no idle cycle).
  - start=0: stay in S_WAIT indefinitely.
- start, mode and data are ignored while in S_COUNT. The latched word cannot be corrupted mid-count.
- Latency without early exit: start sampled at edge k gives busy=1 for N cycles; done=1 first visible after edge k+N.
- bit_count arithmetic is unsigned with width COUNTER_SIZE. It cannot overflow under the parameter rule above.
- Reset asserted in any state at an edge returns all registers to reset values at that edge. A reset concurrent with start wins.
- Illegal states decode to S_IDLE.

Optional Feature:
- Macro: COUNT_ONES_SM_EARLY_EXIT_EN
- Defined: in S_COUNT, if the post-shift shreg value is all zero, transition to S_WAIT at the same edge regardless of chunk.
  - At least one count cycle always occurs.
  - The final bit_count is identical to the non-early-exit result.
- Undefined: every count takes exactly N cycles; no zero-detect logic is built.

Test Plan (WORD_SIZE=8, BITS_PER_CYCLE=2, N=4):
- Reset held 3 cycles, then released with start=0 -> bit_count=0, busy=0, done=0, state stays S_IDLE.
- data=8'hFF, mode=0, 1-cycle start pulse -> busy high 4 cycles; then done=1 with bit_count=8, held until the next start.
- data=8'h00, mode=1 -> bit_count=8. data=8'hA5, mode=1 -> bit_count=4. Both complete in 4 cycles.
- data=8'h03, mode=0:
  - Macro defined: busy high 1 cycle, bit_count=2.
  - Macro undefined: busy high 4 cycles, bit_count=2.
- During a count of 8'h0F, change data to 8'hFF and pulse start -> ignored; final bit_count=4. Then hold start=1 continuously -> back-to-back counts from S_WAIT with no S_IDLE cycle; done drops for exactly the count duration.
- Assert reset for 1 cycle at the 2nd count cycle of 8'hFF -> next cycle bit_count=0, busy=0, done=0, state S_IDLE; a subsequent start for 8'h81 gives bit_count=2.
